aes_cbc_dec_chain: RTL and testbench

CBC-mode wrapper around the pipelined inverse cipher (aes_inv_chiper, ROUND_NUMBER=14). Accepts the ciphertext AXI-Stream, forwards each block to the inverse cipher and queues the chaining mask for it: the IV for the first block of a packet, otherwise the previous ciphertext. Consumes the cipher's output stream and emits plaintext = decrypted block XOR queued mask. The mask queue makes the chaining exact for any cipher latency up to FIFO_DEPTH blocks in flight.

---
 rtl/aes_cbc_dec_chain_pkg.sv | 26 ++
 rtl/aes_sync_fifo.sv | 67 ++++++
 rtl/aes_cbc_dec_chain.sv | 185 ++++++++++++++++++
 tb/tb_aes_cbc_dec_chain.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_cbc_dec_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_cbc_dec_chain_pkg
// Description : Shared types for the CBC decryption chaining wrapper.
//               AES_BLOCK_W - AES block width in bits
//               cbc_mask_t  - one mask-queue entry: chaining mask + tlast
//               in_state_e  - input-side FSM encoding
// Revision    : 1.0 - initial release
// ============================================================================
package aes_cbc_dec_chain_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef struct packed {
    logic [AES_BLOCK_W-1:0] mask;
    logic                   last;
  } cbc_mask_t;

  typedef enum logic [1:0] {
    ST_WAIT_IV = 2'd0,
    ST_FIRST   = 2'd1,
    ST_CHAIN   = 2'd2
  } in_state_e;

endpackage : aes_cbc_dec_chain_pkg
`default_nettype wire

// File: rtl/aes_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : aes_sync_fifo
// Description : Single-clock first-word-fall-through FIFO. head_o always
//               shows the oldest entry (stale when empty_o is high).
//               A push while full is accepted only if a pop happens in the
//               same cycle; a pop while empty is ignored.
// Ports       : clk, resetn       - clock, asynchronous active-low reset
//               push_i, data_i    - write request and data
//               pop_i             - read request (removes head)
//               head_o            - oldest entry
//               full_o, empty_o   - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sync_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 32      // must be a power of two
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  logic do_push;
  logic do_pop;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == FULL_COUNT);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    head_o  = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule : aes_sync_fifo
`default_nettype wire

// File: rtl/aes_cbc_dec_chain.sv
`default_nettype none
// ============================================================================
// Module      : aes_cbc_dec_chain
// Description : CBC-mode chaining wrapper around a pipelined AES inverse
//               cipher. Ciphertext is forwarded to the cipher through a
//               register stage while the matching chaining mask (IV for the
//               first block of a packet, else the previous ciphertext) is
//               queued. Cipher output is XORed with the queued mask to give
//               plaintext.
// Ports       : clk, resetn              - clock, async active-low reset
//               iv_i, iv_valid_i         - IV load
//               s_ct_*                   - ciphertext AXI-Stream in
//               m_cph_*                  - blocks to inverse cipher
//               s_dec_*                  - decrypted blocks from cipher
//               m_pt_*                   - plaintext AXI-Stream out
//               err_o                    - sticky underflow / tlast error
// Revision    : 1.0 - initial release
// ============================================================================
module aes_cbc_dec_chain
  import aes_cbc_dec_chain_pkg::*;
#(
  parameter int TDATA_WIDTH = 128,
  parameter int FIFO_DEPTH  = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [TDATA_WIDTH-1:0] iv_i,
  input  logic                   iv_valid_i,
  input  logic [TDATA_WIDTH-1:0] s_ct_tdata,
  input  logic                   s_ct_tvalid,
  input  logic                   s_ct_tlast,
  output logic                   s_ct_tready,
  output logic [TDATA_WIDTH-1:0] m_cph_tdata,
  output logic                   m_cph_tvalid,
  output logic                   m_cph_tlast,
  input  logic                   m_cph_tready,
  input  logic [TDATA_WIDTH-1:0] s_dec_tdata,
  input  logic                   s_dec_tvalid,
  input  logic                   s_dec_tlast,
  output logic                   s_dec_tready,
  output logic [TDATA_WIDTH-1:0] m_pt_tdata,
  output logic                   m_pt_tvalid,
  output logic                   m_pt_tlast,
  input  logic                   m_pt_tready,
  output logic                   err_o
);

  in_state_e              state_q, state_d;
  logic [TDATA_WIDTH-1:0] iv_q;
  logic [TDATA_WIDTH-1:0] prev_ct_q;

  logic                   cph_valid_q;
  logic                   cph_last_q;
  logic [TDATA_WIDTH-1:0] cph_data_q;

  logic                   pt_valid_q;
  logic                   pt_last_q;
  logic [TDATA_WIDTH-1:0] pt_data_q;
  logic                   err_q;

  logic                   fifo_full;
  logic                   fifo_empty;
  cbc_mask_t              push_entry;
  cbc_mask_t              head_entry;

  logic                   ct_ready;
  logic                   ct_acc;
  logic                   dec_ready;
  logic                   dec_acc;
  logic                   fifo_pop;
  logic                   err_set;
  logic [TDATA_WIDTH-1:0] dec_mask;

  // --------------------------------------------------------------------------
  // Input side: FSM and handshake
  // --------------------------------------------------------------------------
  always_comb begin
    ct_ready = (state_q != ST_WAIT_IV) && !fifo_full &&
               (!cph_valid_q || m_cph_tready);
    ct_acc   = s_ct_tvalid && ct_ready;

    // The mask is taken from the registered IV, so an IV arriving in the
    // same cycle as a first-block accept only applies to the next packet.
    push_entry.mask = (state_q == ST_FIRST) ? iv_q : prev_ct_q;
    push_entry.last = s_ct_tlast;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_IV: if (iv_valid_i)              state_d = ST_FIRST;
      ST_FIRST:   if (ct_acc && !s_ct_tlast)   state_d = ST_CHAIN;
      ST_CHAIN:   if (ct_acc && s_ct_tlast)    state_d = ST_FIRST;
      default:                                 state_d = ST_WAIT_IV;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_WAIT_IV;
      iv_q      <= '0;
      prev_ct_q <= '0;
    end else begin
      state_q <= state_d;
      if (iv_valid_i) iv_q      <= iv_i;
      if (ct_acc)     prev_ct_q <= s_ct_tdata;
    end
  end

  // Register stage towards the cipher; the block is forwarded unmodified.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cph_valid_q <= 1'b0;
      cph_last_q  <= 1'b0;
      cph_data_q  <= '0;
    end else if (ct_acc) begin
      cph_valid_q <= 1'b1;
      cph_last_q  <= s_ct_tlast;
      cph_data_q  <= s_ct_tdata;
    end else if (m_cph_tready) begin
      cph_valid_q <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Mask queue
  // --------------------------------------------------------------------------
  aes_sync_fifo #(
    .WIDTH ($bits(cbc_mask_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_mask_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (ct_acc),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .head_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // --------------------------------------------------------------------------
  // Output side
  // --------------------------------------------------------------------------
  always_comb begin
    // Held low until an IV is loaded so the port idles at 0 out of reset;
    // nothing can be in flight before the first IV anyway.
    dec_ready = (state_q != ST_WAIT_IV) && (!pt_valid_q || m_pt_tready);
    dec_acc   = s_dec_tvalid && dec_ready;
    fifo_pop  = dec_acc && !fifo_empty;
    dec_mask  = fifo_empty ? '0 : head_entry.mask;
    err_set   = dec_acc && (fifo_empty || (s_dec_tlast != head_entry.last));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pt_valid_q <= 1'b0;
      pt_last_q  <= 1'b0;
      pt_data_q  <= '0;
    end else if (dec_acc) begin
      pt_valid_q <= 1'b1;
      pt_last_q  <= s_dec_tlast;
      pt_data_q  <= s_dec_tdata ^ dec_mask;
    end else if (m_pt_tready) begin
      pt_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign s_ct_tready  = ct_ready;
  assign m_cph_tdata  = cph_data_q;
  assign m_cph_tvalid = cph_valid_q;
  assign m_cph_tlast  = cph_last_q;
  assign s_dec_tready = dec_ready;
  assign m_pt_tdata   = pt_data_q;
  assign m_pt_tvalid  = pt_valid_q;
  assign m_pt_tlast   = pt_last_q;
  assign err_o        = err_q;

endmodule : aes_cbc_dec_chain
`default_nettype wire

// File: tb/tb_aes_cbc_dec_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_cbc_dec_chain
// Description : Self-checking bench for aes_cbc_dec_chain. The inverse cipher
//               is a behavioural stand-in that returns the AES-256
//               decryption of the NIST SP800-38A CBC ciphertext blocks
//               (D_i = P_i ^ C_{i-1}) with a small queue-based latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_cbc_dec_chain;

  localparam logic [127:0] IV = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] CT_V [4] = '{
    128'hF58C4C04D6E5F1BA779EABFB5F7BFBD6,
    128'h9CFC4E967EDB808D679F777BC6702C7D,
    128'h39F23369A9D9BACFA530E26304231461,
    128'hB2EB05E2C39BE9FCDA6C19078C6A9D1B };
  localparam logic [127:0] PT_V [4] = '{
    128'h6BC1BEE22E409F96E93D7E117393172A,
    128'hAE2D8A571E03AC9C9EB76FAC45AF8E51,
    128'h30C81C46A35CE411E5FBC1191A0A52EF,
    128'hF69F2445DF4F9B17AD2B417BE66C3710 };
  localparam logic [127:0] INJ_DATA = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [127:0] iv_i = '0;
  logic         iv_valid_i = 1'b0;
  logic [127:0] s_ct_tdata = '0;
  logic         s_ct_tvalid = 1'b0;
  logic         s_ct_tlast = 1'b0;
  logic         s_ct_tready;
  logic [127:0] m_cph_tdata;
  logic         m_cph_tvalid;
  logic         m_cph_tlast;
  logic         m_cph_tready;
  logic [127:0] s_dec_tdata;
  logic         s_dec_tvalid;
  logic         s_dec_tlast;
  logic         s_dec_tready;
  logic [127:0] m_pt_tdata;
  logic         m_pt_tvalid;
  logic         m_pt_tlast;
  logic         m_pt_tready = 1'b1;
  logic         err_o;

  logic         inject = 1'b0;
  logic         flip_last = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed { logic [127:0] d; logic l; } blk_t;
  blk_t stub_q[$];
  blk_t pt_q[$];

  aes_cbc_dec_chain #(.TDATA_WIDTH(128), .FIFO_DEPTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .iv_i         (iv_i),
    .iv_valid_i   (iv_valid_i),
    .s_ct_tdata   (s_ct_tdata),
    .s_ct_tvalid  (s_ct_tvalid),
    .s_ct_tlast   (s_ct_tlast),
    .s_ct_tready  (s_ct_tready),
    .m_cph_tdata  (m_cph_tdata),
    .m_cph_tvalid (m_cph_tvalid),
    .m_cph_tlast  (m_cph_tlast),
    .m_cph_tready (m_cph_tready),
    .s_dec_tdata  (s_dec_tdata),
    .s_dec_tvalid (s_dec_tvalid),
    .s_dec_tlast  (s_dec_tlast),
    .s_dec_tready (s_dec_tready),
    .m_pt_tdata   (m_pt_tdata),
    .m_pt_tvalid  (m_pt_tvalid),
    .m_pt_tlast   (m_pt_tlast),
    .m_pt_tready  (m_pt_tready),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // AES-256 block decryption of the NIST vector blocks under key 603DEB10...
  function automatic logic [127:0] inv_cipher(input logic [127:0] ct);
    case (ct)
      CT_V[0]: return PT_V[0] ^ IV;
      CT_V[1]: return PT_V[1] ^ CT_V[0];
      CT_V[2]: return PT_V[2] ^ CT_V[1];
      CT_V[3]: return PT_V[3] ^ CT_V[2];
      default: return ct;
    endcase
  endfunction

  // Cipher stand-in: accepts while fewer than 40 blocks are held.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stub_q.delete();
      s_dec_tvalid <= 1'b0;
      s_dec_tdata  <= '0;
      s_dec_tlast  <= 1'b0;
      m_cph_tready <= 1'b0;
    end else begin
      if (m_cph_tvalid && m_cph_tready)
        stub_q.push_back({inv_cipher(m_cph_tdata), m_cph_tlast ^ flip_last});
      if (inject)
        stub_q.push_back({INJ_DATA, 1'b0});
      if (!s_dec_tvalid || s_dec_tready) begin
        if (stub_q.size() > 0) begin
          s_dec_tvalid <= 1'b1;
          {s_dec_tdata, s_dec_tlast} <= stub_q.pop_front();
        end else begin
          s_dec_tvalid <= 1'b0;
        end
      end
      m_cph_tready <= (stub_q.size() < 40);
    end
  end

  // Plaintext monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn && m_pt_tvalid && m_pt_tready)
      pt_q.push_back({m_pt_tdata, m_pt_tlast});
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn      = 1'b0;
    s_ct_tvalid = 1'b0;
    iv_valid_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    pt_q.delete();
  endtask

  task automatic load_iv(input logic [127:0] v);
    iv_i = v; iv_valid_i = 1'b1;
    @(posedge clk); #1;
    iv_valid_i = 1'b0;
  endtask

  task automatic send_blk(input logic [127:0] d, input logic l);
    bit ok = 0;
    s_ct_tvalid = 1'b1; s_ct_tdata = d; s_ct_tlast = l;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (s_ct_tready) ok = 1;
      @(posedge clk); #1;
    end
    s_ct_tvalid = 1'b0;
    if (!ok) check("ct_accept_timeout", 128'(ok), 128'(1));
  endtask

  task automatic send_pkts(input int n_pkts);
    for (int p = 0; p < n_pkts; p++)
      for (int b = 0; b < 4; b++) send_blk(CT_V[b], b == 3);
  endtask

  task automatic expect_pt(input int n, input string tag);
    blk_t e;
    int   waited = 0;
    while (pt_q.size() < n && waited < 3000) begin
      @(posedge clk); #1; waited++;
    end
    check({tag, "_count"}, 128'(pt_q.size()), 128'(n));
    for (int i = 0; i < n && pt_q.size() > 0; i++) begin
      e = pt_q.pop_front();
      check($sformatf("%s_data%0d", tag, i), e.d, PT_V[i % 4]);
      check($sformatf("%s_last%0d", tag, i), 128'(e.l), 128'((i % 4) == 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_stall = 0;

    // Reset values (reset asserted from time 0)
    #12;
    check("rst_ct_ready",  128'(s_ct_tready),  128'(0));
    check("rst_cph_valid", 128'(m_cph_tvalid), 128'(0));
    check("rst_cph_last",  128'(m_cph_tlast),  128'(0));
    check("rst_cph_data",  m_cph_tdata,        128'(0));
    check("rst_dec_ready", 128'(s_dec_tready), 128'(0));
    check("rst_pt_valid",  128'(m_pt_tvalid),  128'(0));
    check("rst_pt_last",   128'(m_pt_tlast),   128'(0));
    check("rst_pt_data",   m_pt_tdata,         128'(0));
    check("rst_err",       128'(err_o),        128'(0));

    // No IV loaded: ciphertext offered but never accepted
    @(posedge clk); #1;
    s_ct_tvalid = 1'b1; s_ct_tdata = CT_V[0]; s_ct_tlast = 1'b0;
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("noiv_ct_ready",  128'(s_ct_tready),  128'(0));
    check("noiv_cph_valid", 128'(m_cph_tvalid), 128'(0));
    iv_i = IV; iv_valid_i = 1'b1;
    check("iv_cycle_ready", 128'(s_ct_tready), 128'(0));
    @(posedge clk); #1;
    iv_valid_i = 1'b0;
    check("post_iv_ready", 128'(s_ct_tready), 128'(1));

    // NIST CBC-AES256 single packet
    send_pkts(1);
    expect_pt(4, "nist");
    check("nist_err", 128'(err_o), 128'(0));

    // Same packet twice back-to-back: chain restarts from the IV
    send_pkts(2);
    expect_pt(8, "twice");
    check("twice_err", 128'(err_o), 128'(0));

    // Downstream stall for 50 cycles with 10 packets queued
    m_pt_tready = 1'b0;
    fork
      send_pkts(10);
      begin
        repeat (50) @(negedge clk);
        saw_stall = s_ct_tvalid && !s_ct_tready;
        check("stall_no_output", 128'(pt_q.size()), 128'(0));
        @(posedge clk); #1;
        m_pt_tready = 1'b1;
      end
    join
    check("stall_ct_blocked", 128'(saw_stall), 128'(1));
    expect_pt(40, "stall");
    check("stall_err", 128'(err_o), 128'(0));

    // Asynchronous reset in the middle of a packet
    send_blk(CT_V[0], 1'b0);
    send_blk(CT_V[1], 1'b0);
    repeat (3) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("arst_ct_ready",  128'(s_ct_tready),  128'(0));
    check("arst_cph_valid", 128'(m_cph_tvalid), 128'(0));
    check("arst_cph_data",  m_cph_tdata,        128'(0));
    check("arst_pt_valid",  128'(m_pt_tvalid),  128'(0));
    check("arst_pt_data",   m_pt_tdata,         128'(0));
    check("arst_err",       128'(err_o),        128'(0));
    @(posedge clk); #1;
    resetn = 1'b1;
    pt_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("arst_needs_iv", 128'(s_ct_tready), 128'(0));
    load_iv(IV);
    send_pkts(1);
    expect_pt(4, "arst");
    check("arst_err_after", 128'(err_o), 128'(0));

    // Decrypted block arriving with the mask queue empty
    do_reset();
    load_iv(IV);
    check("inj_err_before", 128'(err_o), 128'(0));
    inject = 1'b1;
    @(posedge clk); #1;
    inject = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("inj_err", 128'(err_o), 128'(1));
    check("inj_count", 128'(pt_q.size()), 128'(1));
    if (pt_q.size() > 0) check("inj_data_nomask", pt_q[0].d, INJ_DATA);
    repeat (10) @(posedge clk);
    #1;
    check("inj_err_sticky", 128'(err_o), 128'(1));

    // tlast mismatch between cipher output and queued entry
    do_reset();
    load_iv(IV);
    flip_last = 1'b1;
    send_blk(CT_V[0], 1'b1);
    repeat (8) @(posedge clk);
    #1;
    flip_last = 1'b0;
    check("tlast_err", 128'(err_o), 128'(1));
    check("tlast_count", 128'(pt_q.size()), 128'(1));
    if (pt_q.size() > 0) check("tlast_data", pt_q[0].d, PT_V[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_aes_cbc_dec_chain
`default_nettype wire
